// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two masters, the shared single-port RAM and the arbiter.
// The arbiter takes the slave view; the surrounding system (or bench) takes the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    m0_cmd;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;

    logic [1:0]    m1_cmd;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          busy;
    logic          err;

    modport slave (
        input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack, ram_addr, ram_write, ram_wdata, busy, err
    );

    modport master (
        output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack, ram_addr, ram_write, ram_wdata, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read RAM between the cpu (master 0)
// and a secondary master (master 1), with a three-state IDLE/ISSUE/RESP sequencer.
module mem_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_ILL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          pri_q, pri_d;
    logic          err_q, err_d;
    logic          grant_q, grant_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          req0, req1, gnt;
    logic [1:0]    ack;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_wdata;
    logic          busy;

    assign req0 = (bus.m0_cmd == CMD_READ) || (bus.m0_cmd == CMD_WRITE);
    assign req1 = (bus.m1_cmd == CMD_READ) || (bus.m1_cmd == CMD_WRITE);

    always_comb begin
        state_d   = state_q;
        pri_d     = pri_q;
        err_d     = err_q;
        grant_d   = grant_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt       = 1'b0;
        ack       = 2'b00;
        rdata0    = '0;
        rdata1    = '0;
        ram_addr  = '0;
        ram_write = 1'b0;
        ram_wdata = '0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((bus.m0_cmd == CMD_ILL) || (bus.m1_cmd == CMD_ILL)) begin
                    err_d = 1'b1;
                end
                // Contention goes to pri; otherwise whichever master is requesting.
                gnt = (req0 && req1) ? pri_q : req1;
                if (req0 || req1) begin
                    grant_d = gnt;
                    wr_d    = gnt ? (bus.m1_cmd == CMD_WRITE) : (bus.m0_cmd == CMD_WRITE);
                    addr_d  = gnt ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                busy     = 1'b1;
                ram_addr = addr_q;
                if (wr_q) begin
                    ram_write    = 1'b1;
                    ram_wdata    = wdata_q;
                    ack[grant_q] = 1'b1;
                    pri_d        = ~grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // RAM data for the address presented in ISSUE arrives this cycle.
                busy         = 1'b1;
                ram_addr     = addr_q;
                ack[grant_q] = 1'b1;
                if (grant_q) begin
                    rdata1 = bus.ram_rdata;
                end else begin
                    rdata0 = bus.ram_rdata;
                end
                pri_d   = ~grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.m0_ack    = ack[0];
    assign bus.m1_ack    = ack[1];
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;
    assign bus.ram_addr  = ram_addr;
    assign bus.ram_write = ram_write;
    assign bus.ram_wdata = ram_wdata;
    assign bus.busy      = busy;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a RAM model with one-cycle read latency,
// and a scoreboard of expected transactions popped whenever a master is acked.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    typedef struct {
        logic          m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic m, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.m0_ack && bus.m1_ack) chk("ack_overlap", 1, 0);
            for (int m = 0; m < 2; m++) begin
                if ((m == 0) ? bus.m0_ack : bus.m1_ack) begin
                    if (sb.size() == 0) begin
                        chk("spurious_ack", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_master", m, {31'd0, e.m});
                        chk("sb_addr", bus.ram_addr, e.addr);
                        if (e.wr) begin
                            chk("sb_wr_en", bus.ram_write, 1);
                            chk("sb_wdata", bus.ram_wdata, e.data);
                        end else begin
                            chk("sb_rdata", (m == 0) ? bus.m0_rdata : bus.m1_rdata, e.data);
                            chk("sb_rdata_other", (m == 0) ? bus.m1_rdata : bus.m0_rdata, 0);
                        end
                    end
                end
            end
        end
    end

    int cyc, n0, n1, last0, last1;

    initial begin
        reset = 1'b1;
        bus.m0_cmd = 2'b00; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_cmd = 2'b00; bus.m1_addr = '0; bus.m1_wdata = '0;
        mem[3]     <= 16'h3333;
        mem[5]     <= 16'h0000;
        mem[7]     <= 16'h0000;
        mem[9'h10] <= 16'h0000;
        mem[9'h20] <= 16'h2020;
        mem[9'h21] <= 16'h2121;

        repeat (2) tick();
        chk("rst_outputs", {bus.busy, bus.ram_write, bus.m0_ack, bus.m1_ack, bus.err}, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        reset = 1'b0;
        tick();

        // Single write from master 0.
        bus.m0_cmd = 2'b10; bus.m0_addr = 9'h005; bus.m0_wdata = 16'hABCD;
        push(1'b0, 1'b1, 9'h005, 16'hABCD);
        chk("w_c1_busy", bus.busy, 0);
        tick();
        chk("w_c2_ram_write", bus.ram_write, 1);
        chk("w_c2_ram_addr", bus.ram_addr, 9'h005);
        chk("w_c2_ram_wdata", bus.ram_wdata, 16'hABCD);
        chk("w_c2_m0_ack", bus.m0_ack, 1);
        bus.m0_cmd = 2'b00;
        tick();
        chk("w_c3_busy", bus.busy, 0);
        chk("w_c3_ram_write", bus.ram_write, 0);
        chk("w_mem5", mem[5], 16'hABCD);

        // Single read from master 1 of the word just written.
        bus.m1_cmd = 2'b01; bus.m1_addr = 9'h005;
        push(1'b1, 1'b0, 9'h005, 16'hABCD);
        chk("r_c1_ram_write", bus.ram_write, 0);
        tick();
        chk("r_c2_ram_write", bus.ram_write, 0);
        chk("r_c2_m1_ack", bus.m1_ack, 0);
        tick();
        chk("r_c3_m1_ack", bus.m1_ack, 1);
        chk("r_c3_m1_rdata", bus.m1_rdata, 16'hABCD);
        chk("r_c3_m0_rdata", bus.m0_rdata, 0);
        chk("r_c3_ram_write", bus.ram_write, 0);
        bus.m1_cmd = 2'b00;
        tick();
        chk("r_c4_busy", bus.busy, 0);

        // Inputs changing after the grant edge must not leak into the transaction.
        bus.m0_cmd = 2'b10; bus.m0_addr = 9'h007; bus.m0_wdata = 16'h5555;
        push(1'b0, 1'b1, 9'h007, 16'h5555);
        tick();
        bus.m0_addr = 9'h003;
        #1;
        chk("chg_ram_addr", bus.ram_addr, 9'h007);
        bus.m0_cmd = 2'b00;
        tick();
        chk("chg_mem7", mem[7], 16'h5555);
        chk("chg_mem3", mem[3], 16'h3333);

        // Illegal command on master 1 alongside a legal write on master 0.
        bus.m0_cmd = 2'b10; bus.m0_addr = 9'h010; bus.m0_wdata = 16'h1234;
        bus.m1_cmd = 2'b11;
        push(1'b0, 1'b1, 9'h010, 16'h1234);
        chk("ill_c1_err", bus.err, 0);
        tick();
        chk("ill_c2_err", bus.err, 1);
        chk("ill_c2_m0_ack", bus.m0_ack, 1);
        chk("ill_c2_m1_ack", bus.m1_ack, 0);
        bus.m0_cmd = 2'b00;
        tick();
        chk("ill_c3_m1_ack", bus.m1_ack, 0);
        chk("ill_c3_busy", bus.busy, 0);
        bus.m1_cmd = 2'b00;
        repeat (3) tick();
        chk("ill_err_sticky", bus.err, 1);
        chk("ill_mem10", mem[9'h10], 16'h1234);

        // Reset during the RESP cycle of a master 0 read: no scoreboard entry, the read is aborted.
        bus.m0_cmd = 2'b01; bus.m0_addr = 9'h020;
        tick();
        tick();
        chk("rst_resp_ack_before", bus.m0_ack, 1);
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", {bus.ram_write, bus.m0_ack, bus.busy, bus.err}, 0);
        bus.m0_cmd = 2'b00;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_quiet", {bus.busy, bus.ram_write, bus.m0_ack, bus.m1_ack,
                                   bus.err, bus.ram_addr}, 0);
        end

        // Both masters read continuously from reset: grants alternate 0,1,0,1.
        reset = 1'b1;
        bus.m0_cmd = 2'b01; bus.m0_addr = 9'h020;
        bus.m1_cmd = 2'b01; bus.m1_addr = 9'h021;
        push(1'b0, 1'b0, 9'h020, 16'h2020);
        push(1'b1, 1'b0, 9'h021, 16'h2121);
        push(1'b0, 1'b0, 9'h020, 16'h2020);
        push(1'b1, 1'b0, 9'h021, 16'h2121);
        tick();
        reset = 1'b0;
        cyc = 1; n0 = 0; n1 = 0; last0 = 0; last1 = 0;
        for (int k = 0; k < 30 && (bus.m0_cmd != 2'b00 || bus.m1_cmd != 2'b00); k++) begin
            tick();
            cyc++;
            if (bus.m0_ack) begin
                n0++;
                if (n0 == 1) chk("cont_m0_first", cyc, 3);
                else         chk("cont_m0_spacing", cyc - last0, 6);
                last0 = cyc;
                if (n0 == 2) bus.m0_cmd = 2'b00;
            end
            if (bus.m1_ack) begin
                n1++;
                if (n1 == 1) chk("cont_m1_first", cyc, 6);
                else         chk("cont_m1_spacing", cyc - last1, 6);
                last1 = cyc;
                if (n1 == 2) bus.m1_cmd = 2'b00;
            end
        end
        chk("cont_m0_count", n0, 2);
        chk("cont_m1_count", n1, 2);
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two bus masters.
  - Master 0 is the cpu memory interface.
  - Master 1 is a secondary master: boot loader, debug or DMA.
- Uses the cpu memory command encoding: 2'b01 = MREAD, 2'b10 = MWRITE, 2'b00 = none.
- Applies round-robin arbitration with a 3-state sequencer.
- Accounts for the RAM's one-cycle synchronous read latency.
- Sits between cpu mem_cmd/mem_addr/write_data/read_data and the RAM.

Parameters:
- AW, 9, address width; matches cpu mem_addr.
- DW, 16, data width; matches cpu read_data/write_data.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- m0_cmd  input  2  master 0 command: 01 read, 10 write, 00 idle, 11 illegal.
- m0_addr  input  AW  master 0 address.
- m0_wdata  input  DW  master 0 write data.
- m0_rdata  output  DW  master 0 read data; valid only while m0_ack=1 on a read.
- m0_ack  output  1  master 0 completion pulse, one cycle.
- m1_cmd, m1_addr, m1_wdata, m1_rdata, m1_ack: same as the master 0 ports, for master 1.
- ram_addr  output  AW  RAM address.
- ram_write  output  1  RAM write enable.
- ram_wdata  output  DW  RAM write data.
- ram_rdata  input  DW  RAM read data; valid one cycle after ram_addr is presented.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky illegal-command flag.

Behaviour:
- Reset is asynchronous, active-high, and takes effect immediately.
  - state=IDLE, pri=0 (master 0 favoured), err=0.
  - All outputs 0, including ram_write, both acks, both rdata, busy and ram_addr.
  - Latched grant/cmd/addr/wdata registers cleared.
- A request is mN_cmd ∈ {01,10}. Command 11 is not a request.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - No RAM activity; ram_addr=0, ram_wdata=0.
  - If both masters request: grant = pri.
  - If one master requests: grant that master.
  - Grant edge: latch grant, cmd, addr and wdata of the granted master, then go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - ram_addr = latched addr.
  - Write: ram_write=1 and ram_wdata = latched wdata for exactly this cycle; ack[grant]=1 in this same cycle.
    - On the edge: pri <= ~grant, next state IDLE.
  - Read: ram_write=0; on the edge go to RESP.
- RESP:
  - ram_addr held at the latched addr.
  - ack[grant]=1; mN_rdata[grant] = ram_rdata (combinational). The other master's rdata = 0.
  - On the edge: pri <= ~grant, next state IDLE.
- Latency, counted from the first IDLE cycle with the request visible:
  - Write ack in cycle 2.
  - Read ack and data in cycle 3.
  - At least one IDLE bubble between transactions.
- Master rules:
  - A master holds cmd/addr/wdata until its ack.
  - A master must change cmd to 00 or a new command at the edge where ack=1.
  - A cmd still asserted in the following IDLE cycle is a new transaction.
  - Inputs changing after the grant edge do not affect the current transaction.
- Fairness:
  - With both masters requesting continuously, grants strictly alternate.
  - A waiting master is granted within one transaction of the other.
- err:
  - Set to 1 at any edge where state=IDLE and either mN_cmd==11.
  - Cleared only by reset.
  - An illegal command is never granted, never acked, and does not move pri.
  - A legal request on the other master in the same cycle is still serviced.
- Reset mid-transaction:
  - Aborts the transaction; no ack is issued after reset deasserts.
  - A write in ISSUE has ram_write forced to 0 asynchronously.
- Unused state encodings recover to IDLE on the next edge, with all outputs 0.
- Arithmetic: none beyond the pri toggle. The address is passed through unmodified, with no wrap or translation.

Test Plan:
- Reset: assert reset during RESP of an m0 read -> immediately ram_write=0, m0_ack=0, busy=0. After release with no cmds, all outputs stay 0 and no ack ever appears.
- Single write: m0_cmd=10, m0_addr=9'h005, m0_wdata=16'hABCD held from cycle 1 -> cycle 2 shows ram_write=1, ram_addr=5, ram_wdata=ABCD, m0_ack=1. Cycle 3 is IDLE with busy=0.
- Single read (RAM model pre-loaded with mem[5]=ABCD): m1_cmd=01, m1_addr=5 -> cycle 3 shows m1_ack=1, m1_rdata=ABCD, m0_rdata=0. ram_write stays 0 throughout.
- Contention: both masters issue reads continuously from reset, each re-asserting after ack -> grant order is 0,1,0,1. Acks never coincide. Each master's read-ack spacing is 6 cycles.
- Illegal command: m1_cmd=11 while m0_cmd=10 -> m0 write completes normally, m1_ack never asserts, err=1. err stays 1 after m1_cmd=00 until reset.
- Input change after grant: m0 write to addr 7; m0_addr changed to 3 in the ISSUE cycle -> ram_addr=7 and RAM location 3 is untouched.
